instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader.sv | 143 ++++++++++++++
 tb/tb_instr_loader.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// instr_loader: receives a byte stream (length N, then N big-endian 16-bit
// words, then an optional checksum byte) and writes the words into an
// instruction memory write port at addresses 0..N-1.
// Optional feature macro: LOADER_CHECKSUM_EN. When it is defined, the loader
// keeps an XOR of the length and data bytes, consumes a trailing checksum byte,
// and raises a sticky error flag when that byte does not match.
`timescale 1ns/1ps
module instr_loader (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [8:0]  words_loaded
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN  = 3'd1;
    localparam logic [2:0] S_HI   = 3'd2;
    localparam logic [2:0] S_LO   = 3'd3;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHK  = 3'd4;
`endif
    localparam logic [2:0] S_FIN  = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [7:0]  len_q;
    logic [7:0]  idx_q;
    logic [15:0] data_q;
    logic [8:0]  cnt_q;
    logic        pend_q;   // a word was completed last cycle; write it now
    logic        last_q;   // the pending word is the final word of the load
    logic        xfer;
    logic        last_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum_q;
    logic        err_q;
`endif

    assign xfer      = byte_valid && byte_ready;
    // The previous word's write always retires before the next low byte can
    // arrive (a high byte sits between them), so idx_q is current here.
    assign last_word = (idx_q == (len_q - 8'd1));

    assign byte_ready = (state_q == S_LEN) || (state_q == S_HI) || (state_q == S_LO)
`ifdef LOADER_CHECKSUM_EN
                        || (state_q == S_CHK)
`endif
                        ;
    // A write pending from LO must not escape in the cycle reset is applied.
    assign wr_en        = pend_q && !rst;
    assign wr_addr      = idx_q;
    assign wr_data      = data_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_FIN);
    assign words_loaded = cnt_q;
`ifdef LOADER_CHECKSUM_EN
    assign error        = err_q;
`else
    assign error        = 1'b0;
`endif

    // Next-state selection for the load sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_LEN;
            S_LEN:  if (xfer)  state_d = (byte_in == 8'd0) ? S_FIN : S_HI;
            S_HI:   if (xfer)  state_d = S_LO;
            S_LO: begin
                if (xfer) begin
                    if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_FIN;
`endif
                    end else begin
                        state_d = S_HI;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK:  if (xfer)  state_d = S_FIN;
`endif
            S_FIN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, word assembly, write retirement and checksum bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= 8'd0;
            idx_q   <= 8'd0;
            data_q  <= 16'd0;
            cnt_q   <= 9'd0;
            pend_q  <= 1'b0;
            last_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= 8'd0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pend_q  <= (state_q == S_LO) && xfer;
            if (state_q == S_IDLE && start) begin
                idx_q <= 8'd0;
                cnt_q <= 9'd0;
`ifdef LOADER_CHECKSUM_EN
                csum_q <= 8'd0;
                err_q  <= 1'b0;
`endif
            end
            if (state_q == S_LEN && xfer) len_q <= byte_in;
            if (state_q == S_HI && xfer)  data_q[15:8] <= byte_in;
            if (state_q == S_LO && xfer) begin
                data_q[7:0] <= byte_in;
                last_q      <= last_word;
            end
            // The index stops at N-1 so it never points past the last word.
            if (pend_q) begin
                cnt_q <= cnt_q + 9'd1;
                if (!last_q) idx_q <= idx_q + 8'd1;
            end
`ifdef LOADER_CHECKSUM_EN
            if (xfer && (state_q == S_LEN || state_q == S_HI || state_q == S_LO))
                csum_q <= csum_q ^ byte_in;
            if (state_q == S_CHK && xfer)
                err_q <= (byte_in != csum_q);
`endif
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Testbench for instr_loader: directed and randomized program loads, checked
// against a reference built from the stream format (expected write list,
// done count, word count and error flag). Honours LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        rst, start, byte_valid;
    logic [7:0]  byte_in;
    logic        byte_ready, wr_en, busy, done, error;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic [8:0]  words_loaded;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [23:0] got[$];      // observed writes as {addr, data}
    logic [15:0] words[$];    // program for the next load
    bit tog = 1'b0;

    instr_loader dut (
        .clk(clk), .rst(rst), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
        .error(error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // Record every write strobe and done pulse mid-cycle.
    always @(negedge clk) begin
        if (wr_en === 1'b1) got.push_back({wr_addr, wr_data});
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one byte until it is accepted; mode 0 valid always, 1 toggling, 2 random.
    task automatic send_byte(input logic [7:0] b, input int mode, output int cyc);
        bit x;
        cyc = 0;
        for (int k = 0; k < 64; k++) begin
            if (mode == 0) byte_valid = 1'b1;
            else if (mode == 1) begin tog = ~tog; byte_valid = tog; end
            else byte_valid = 1'($urandom_range(0, 1));
            byte_in = byte_valid ? b : 8'($urandom);
            @(negedge clk);
            x = byte_valid && byte_ready;
            @(posedge clk); #1;
            cyc++;
            if (x) return;
        end
        chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_load(input int mode, input bit start_mid, input bit bad_csum, input string tag);
        logic [7:0] s[$];
        logic [7:0] cs;
        logic [7:0] ib;
        int n, g0, d0, cyc, tot;
        bit exp_err;
        n = words.size();
        s.push_back(n[7:0]);
        cs = n[7:0];
        foreach (words[i]) begin
            s.push_back(words[i][15:8]);
            s.push_back(words[i][7:0]);
            cs = cs ^ words[i][15:8] ^ words[i][7:0];
        end
        exp_err = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        if (n != 0) begin
            s.push_back(bad_csum ? 8'hFF : cs);
            exp_err = bad_csum && (cs != 8'hFF);
        end
`endif
        g0 = got.size();
        d0 = done_cnt;
        byte_valid = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        chk({tag, "_error_cleared"}, 32'(error), 32'd0);
        chk({tag, "_count_cleared"}, 32'(words_loaded), 32'd0);
        tot = 0;
        foreach (s[i]) begin
            if (start_mid && i == 3) begin
                byte_valid = 1'b0;
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
            send_byte(s[i], mode, cyc);
            tot += cyc;
        end
        byte_valid = 1'b0;
        if (mode == 0) chk({tag, "_no_stall_cycles"}, 32'(tot), 32'(s.size()));
        for (int k = 0; k < 20 && busy; k++) begin
            @(posedge clk); #1;
        end
        chk({tag, "_idle_at_end"}, 32'(busy), 32'd0);
        chk({tag, "_num_writes"}, 32'(got.size() - g0), 32'(n));
        for (int i = 0; i < n; i++) begin
            ib = i[7:0];
            if (g0 + i < got.size())
                chk($sformatf("%s_write%0d", tag, i), 32'(got[g0 + i]), 32'({ib, words[i]}));
        end
        chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        chk({tag, "_words_loaded"}, 32'(words_loaded), 32'(n));
        chk({tag, "_error"}, 32'(error), 32'(exp_err));
    endtask

    initial begin
        int cyc, g0, n;
        rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_words_loaded", 32'(words_loaded), 32'd0);
        chk("rst_byte_ready", 32'(byte_ready), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_byte_ready", 32'(byte_ready), 32'd0);

        // Basic two-word load.
        words = '{16'h1234, 16'hABCD};
        run_load(0, 1'b0, 1'b0, "basic");

        // Empty program.
        words = {};
        run_load(0, 1'b0, 1'b0, "empty");

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum: writes still happen, error is sticky until next start.
        words = '{16'h1234, 16'hABCD};
        run_load(0, 1'b0, 1'b1, "badcsum");
        repeat (3) @(posedge clk);
        #1;
        chk("badcsum_sticky", 32'(error), 32'd1);
`endif

        // Reset in the cycle after the low byte of word 0 is accepted.
        g0 = got.size();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        send_byte(8'h02, 0, cyc);
        send_byte(8'h12, 0, cyc);
        send_byte(8'h34, 0, cyc);
        rst = 1'b1;
        byte_valid = 1'b0;
        @(negedge clk);
        chk("abort_wr_en", 32'(wr_en), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_words_loaded", 32'(words_loaded), 32'd0);
        chk("abort_wr_addr", 32'(wr_addr), 32'd0);
        chk("abort_wr_data", 32'(wr_data), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_write", 32'(got.size() - g0), 32'd0);

        // Toggling valid with a stray start during the load.
        words = {};
        for (int i = 0; i < 3; i++) words.push_back(16'($urandom));
        run_load(1, 1'b1, 1'b0, "toggle");

        // Randomized loads with random valid gaps.
        for (int t = 0; t < 5; t++) begin
            words = {};
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) words.push_back(16'($urandom));
            run_load(2, 1'b0, 1'b0, $sformatf("rand%0d", t));
        end

        // Maximum-length program: addresses 0..254, no wrap.
        words = {};
        for (int i = 0; i < 255; i++) words.push_back(16'($urandom));
        run_load(0, 1'b0, 1'b0, "max");
        chk("max_final_addr", 32'(wr_addr), 32'd254);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
